// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: redirect/stall inputs and PC outputs of the fetch-stage PC sequencer
interface pc_fetch_unit_if;
  logic        PCSrc;
  logic [31:0] PCNew;
  logic        Stall;
  logic [31:0] PCOut;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        RedirectPending;
  logic        MisalignErr;
  modport master (
    output PCSrc, PCNew, Stall,
    input  PCOut, PCPlus4, Flush, RedirectPending, MisalignErr
  );
  modport slave (
    input  PCSrc, PCNew, Stall,
    output PCOut, PCPlus4, Flush, RedirectPending, MisalignErr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and next-PC sequencer with stall-time redirect buffering
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_fetch_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, HOLD, HOLD_REDIR} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_pend, w_pc, w_pend, w_tgt;
  logic        r_flush, r_mis, w_flush, w_mis, w_load;
  always_comb begin
    w_next  = r_state;
    w_pend  = r_pend;
    w_pc    = r_pc;
    w_load  = 1'b0;
    w_tgt   = bus.PCSrc ? bus.PCNew : r_pend;
    if (bus.Stall) begin
      w_pend = bus.PCSrc ? bus.PCNew : r_pend;
      w_next = bus.PCSrc ? HOLD_REDIR : (r_state == RUN ? HOLD : r_state);
    end else begin
      w_next = RUN;
      w_load = bus.PCSrc || r_state == HOLD_REDIR;
      w_pc   = w_load ? {w_tgt[31:2], 2'b00} : r_pc + 32'd4;
    end
    w_flush = w_load;
    // alignment is judged only when a target actually lands in the PC
    w_mis   = r_mis | (w_load & |w_tgt[1:0]);
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_pend  <= 32'd0;
      r_flush <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc;
      r_pend  <= w_pend;
      r_flush <= w_flush;
      r_mis   <= w_mis;
    end
  end
  assign bus.PCOut           = r_pc;
  assign bus.PCPlus4         = r_pc + 32'd4;
  assign bus.Flush           = r_flush;
  assign bus.RedirectPending = r_state == HOLD_REDIR;
  assign bus.MisalignErr     = r_mis;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table plus randomized run against a behavioural PC model
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  pc_fetch_unit_if bus();
  pc_fetch_unit #(.RESET_PC(32'h00000000)) dut (.Clk(clk), .Reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        src;
    logic [31:0] nw;
    logic [31:0] pc;
    logic        fl;
    logic        rp;
    logic        me;
  } vec_t;
  vec_t tv[$];
  logic [31:0] m_pc, m_pend;
  logic        m_pv, m_fl, m_me;
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic p, input logic [31:0] n);
    rst_n = r;
    bus.Stall = s;
    bus.PCSrc = p;
    bus.PCNew = n;
    @(posedge clk);
    #1;
  endtask
  task automatic compare(input int idx, input logic [31:0] pc, input logic fl, input logic rp, input logic me);
    check("PCOut", idx, bus.PCOut, pc);
    check("PCPlus4", idx, bus.PCPlus4, pc + 32'd4);
    check("Flush", idx, {31'd0, bus.Flush}, {31'd0, fl});
    check("RedirectPending", idx, {31'd0, bus.RedirectPending}, {31'd0, rp});
    check("MisalignErr", idx, {31'd0, bus.MisalignErr}, {31'd0, me});
  endtask
  function automatic void add(logic r, logic s, logic p, logic [31:0] n, logic [31:0] pc, logic fl, logic rp, logic me);
    tv.push_back('{r, s, p, n, pc, fl, rp, me});
  endfunction
  // redirect rules: a live PCSrc beats anything buffered; newest buffered target wins
  task automatic model(input logic r, input logic s, input logic p, input logic [31:0] n);
    logic [31:0] t;
    logic        take;
    if (!r) begin
      m_pc = 32'h0; m_pv = 1'b0; m_pend = 32'h0; m_fl = 1'b0; m_me = 1'b0;
    end else if (s) begin
      m_fl = 1'b0;
      if (p) begin m_pend = n; m_pv = 1'b1; end
    end else begin
      take = p || m_pv;
      t = p ? n : m_pend;
      if (take) begin
        m_pc = t & 32'hFFFFFFFC;
        m_me = m_me || (t % 4 != 0);
      end else m_pc = m_pc + 32'd4;
      m_fl = take;
      m_pv = 1'b0;
    end
  endtask
  initial begin
    add(0, 0, 0, 32'h0,   32'h0,   0, 0, 0);
    add(1, 0, 0, 32'h0,   32'h4,   0, 0, 0);
    add(1, 0, 0, 32'h0,   32'h8,   0, 0, 0);
    add(1, 0, 0, 32'h0,   32'hC,   0, 0, 0);
    add(1, 0, 0, 32'h0,   32'h10,  0, 0, 0);
    add(0, 0, 0, 32'h0,   32'h0,   0, 0, 0);
    add(1, 0, 0, 32'h0,   32'h4,   0, 0, 0);
    add(1, 0, 0, 32'h0,   32'h8,   0, 0, 0);
    add(1, 0, 1, 32'h40,  32'h40,  1, 0, 0);
    add(1, 0, 0, 32'h0,   32'h44,  0, 0, 0);
    add(1, 1, 1, 32'h80,  32'h44,  0, 1, 0);
    add(1, 1, 0, 32'h0,   32'h44,  0, 1, 0);
    add(1, 1, 0, 32'h0,   32'h44,  0, 1, 0);
    add(1, 0, 0, 32'h0,   32'h80,  1, 0, 0);
    add(1, 0, 0, 32'h0,   32'h84,  0, 0, 0);
    add(1, 1, 1, 32'h80,  32'h84,  0, 1, 0);
    add(1, 1, 1, 32'hA0,  32'h84,  0, 1, 0);
    add(1, 0, 0, 32'h0,   32'hA0,  1, 0, 0);
    add(1, 1, 1, 32'h80,  32'hA0,  0, 1, 0);
    add(1, 0, 1, 32'hC0,  32'hC0,  1, 0, 0);
    add(1, 1, 0, 32'h0,   32'hC0,  0, 0, 0);
    add(1, 1, 0, 32'h0,   32'hC0,  0, 0, 0);
    add(1, 0, 0, 32'h0,   32'hC4,  0, 0, 0);
    add(1, 0, 1, 32'h43,  32'h40,  1, 0, 1);
    add(1, 0, 1, 32'h100, 32'h100, 1, 0, 1);
    add(1, 0, 0, 32'h0,   32'h104, 0, 0, 1);
    add(1, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 1);
    add(1, 0, 0, 32'h0,   32'h0,   0, 0, 1);
    add(1, 1, 1, 32'h80,  32'h0,   0, 1, 1);
    add(0, 1, 1, 32'h80,  32'h0,   0, 0, 0);
    add(1, 1, 0, 32'h0,   32'h0,   0, 0, 0);
    add(1, 0, 0, 32'h0,   32'h4,   0, 0, 0);
    add(1, 1, 1, 32'h82,  32'h4,   0, 1, 0);
    add(1, 0, 0, 32'h0,   32'h80,  1, 0, 1);
    rst_n = 1'b0; bus.Stall = 1'b0; bus.PCSrc = 1'b0; bus.PCNew = 32'h0;
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst_n, tv[i].stall, tv[i].src, tv[i].nw);
      compare(i, tv[i].pc, tv[i].fl, tv[i].rp, tv[i].me);
    end
    step(0, 0, 0, 32'h0);
    model(0, 0, 0, 32'h0);
    compare(1000, m_pc, m_fl, m_pv, m_me);
    for (int i = 0; i < 2000; i++) begin
      logic        r, s, p;
      logic [31:0] n;
      r = $urandom_range(0, 99) != 0;
      s = $urandom_range(0, 9) < 4;
      p = $urandom_range(0, 9) < 3;
      n = $urandom_range(0, 3) == 0 ? $urandom() : ($urandom() & 32'hFFFFFFFC);
      if ($urandom_range(0, 15) == 0) n = 32'hFFFFFFFC;
      step(r, s, p, n);
      model(r, s, p, n);
      compare(2000 + i, m_pc, m_fl, m_pv, m_me);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
